// File: rtl/baccarat_pkg.sv
// baccarat_pkg
// Shared types and helpers for the Baccarat hand controller.
//   bstate_t     : controller state encoding
//   card_value() : rank (0..13) to Baccarat point value (10..13 count as 0)
//   NATURAL_MIN, PLAYER_STAND_MIN : score thresholds used by the tableau
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        P1   = 4'd1,
        D1   = 4'd2,
        P2   = 4'd3,
        D2   = 4'd4,
        CHK  = 4'd5,
        P3   = 4'd6,
        BCHK = 4'd7,
        D3   = 4'd8,
        DONE = 4'd9
    } bstate_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_controller_banker_rule.sv
// banker_rule
// Combinational banker third-card decision, evaluated after the player
// has drawn a third card.
// Ports:
//   dscore : in  4  dealer score (0..9)
//   pcard3 : in  4  player third-card rank (1..13)
//   draw   : out 1  dealer takes a third card
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_controller.sv
// baccarat_controller
// Moore controller for one Baccarat hand: deals the four opening cards,
// applies the player and banker third-card rules, then lights the winner.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | after reset, nothing loaded
// P1    | load player card 1
// D1    | load dealer card 1
// P2    | load player card 2
// D2    | load dealer card 2
// CHK   | evaluate naturals / player draw / dealer draw
// P3    | load player card 3
// BCHK  | banker tableau using the player's third card
// D3    | load dealer card 3
// DONE  | hand over, win lights valid until reset
//
// Ports:
//   slow_clock       : in  1  clock (debounced pushbutton)
//   resetb           : in  1  async active-low reset
//   pscore, dscore   : in  4  live hand scores from the datapath
//   pcard3           : in  4  player third-card rank
//   load_pcard1..3   : out 1  player card load strobes
//   load_dcard1..3   : out 1  dealer card load strobes
//   player_win_light : out 1  player wins or ties
//   dealer_win_light : out 1  dealer wins or ties
module baccarat_controller
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    bstate_t state;
    bstate_t next_state;
    logic    banker_draw;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state       = state;
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;

        case (state)
            IDLE: next_state = P1;
            P1: begin
                load_pcard1 = 1'b1;
                next_state  = D1;
            end
            D1: begin
                load_dcard1 = 1'b1;
                next_state  = P2;
            end
            P2: begin
                load_pcard2 = 1'b1;
                next_state  = D2;
            end
            D2: begin
                load_dcard2 = 1'b1;
                next_state  = CHK;
            end
            CHK: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    next_state = DONE;
                else if (pscore < PLAYER_STAND_MIN)
                    next_state = P3;
                // Player stood on 6/7; dealer draws on 0..5.
                else if (dscore < PLAYER_STAND_MIN)
                    next_state = D3;
                else
                    next_state = DONE;
            end
            P3: begin
                load_pcard3 = 1'b1;
                next_state  = BCHK;
            end
            BCHK: next_state = banker_draw ? D3 : DONE;
            D3: begin
                load_dcard3 = 1'b1;
                next_state  = DONE;
            end
            DONE: begin
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
                next_state       = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_baccarat_controller.sv
module tb_baccarat_controller;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    baccarat_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    always #5 slow_clock = ~slow_clock;

    // Output vector bit positions: {p1,p2,p3,d1,d2,d3,pw,dw}
    localparam logic [7:0] L_P1 = 8'h80;
    localparam logic [7:0] L_P2 = 8'h40;
    localparam logic [7:0] L_P3 = 8'h20;
    localparam logic [7:0] L_D1 = 8'h10;
    localparam logic [7:0] L_D2 = 8'h08;
    localparam logic [7:0] L_D3 = 8'h04;
    localparam logic [7:0] PW   = 8'h02;
    localparam logic [7:0] DW   = 8'h01;

    logic [7:0] act;
    assign act = {load_pcard1, load_pcard2, load_pcard3,
                  load_dcard1, load_dcard2, load_dcard3,
                  player_win_light, dealer_win_light};

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    // Banker draw masks indexed by dealer score, bit = player third-card value.
    logic [9:0] bank_mask [0:7];
    initial begin
        bank_mask[0] = 10'b11_1111_1111;
        bank_mask[1] = 10'b11_1111_1111;
        bank_mask[2] = 10'b11_1111_1111;
        bank_mask[3] = 10'b10_1111_1111;
        bank_mask[4] = 10'b00_1111_1100;
        bank_mask[5] = 10'b00_1111_0000;
        bank_mask[6] = 10'b00_1100_0000;
        bank_mask[7] = 10'b00_0000_0000;
    end

    task automatic push(input logic [7:0] val, input string name);
        exp_t e;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic [7:0] val, input string name);
        @(posedge slow_clock);
        #2;
        push(val, name);
    endtask

    task automatic idle_step();
        @(posedge slow_clock);
        #2;
    endtask

    function automatic logic [7:0] lights(input logic [3:0] p, input logic [3:0] d);
        return {6'b0, (p >= d), (d >= p)};
    endfunction

    // Async reset from mid-cycle, one edge under reset, release, deal up to CHK.
    task automatic start_hand();
        #4;
        resetb = 1'b0;
        #1;
        push(8'h00, "async_reset");
        ->chk_ev;
        step(8'h00, "reset_edge");
        resetb = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        step(L_P1, "e1_p1");
        step(L_D1, "e2_d1");
        step(L_P2, "e3_p2");
        step(L_D2, "e4_d2");
        step(8'h00, "e5_chk");
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge slow_clock or chk_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.val);
                end
            end
        end
    end

    // Load strobe sanity: at most one load, never the same load twice in a row.
    logic [5:0] prev_loads = 6'b0;
    always @(negedge slow_clock) begin
        if (resetb) begin
            checks++;
            if ($countones(act[7:2]) > 1 || (act[7:2] != 6'b0 && act[7:2] == prev_loads)) begin
                errors++;
                $display("FAIL load_strobe: got %b prev %b required one-hot non-repeating",
                         act[7:2], prev_loads);
            end
            prev_loads <= act[7:2];
        end else begin
            prev_loads <= 6'b0;
        end
    end

    initial begin
        logic [3:0] v;
        logic       draw;
        logic [7:0] fin;

        @(posedge slow_clock);
        #2;

        // Natural on player side
        start_hand();
        pscore = 4'd9; dscore = 4'd3;
        step(PW, "natural_done");
        step(PW, "natural_hold");

        // Dealer natural
        start_hand();
        pscore = 4'd2; dscore = 4'd8;
        step(DW, "dealer_natural");

        // Both stand, tie
        start_hand();
        pscore = 4'd6; dscore = 4'd6;
        step(PW | DW, "both_stand_tie");

        // Player stands on 7, dealer draws on 4, final tie at 7
        start_hand();
        pscore = 4'd7; dscore = 4'd4;
        step(L_D3, "stand_d3_load");
        dscore = 4'd7;
        step(PW | DW, "stand_d3_tie");

        // Player draws, dealer on 3 with third card 8: dealer stands
        start_hand();
        pscore = 4'd4; dscore = 4'd3;
        step(L_P3, "p3_load");
        pcard3 = 4'd8; pscore = 4'd2;
        step(8'h00, "bchk_8");
        step(DW, "d3_skipped_8");

        // Same with a queen (value 0): dealer draws
        start_hand();
        pscore = 4'd4; dscore = 4'd3;
        step(L_P3, "p3_load_q");
        pcard3 = 4'd12;
        step(8'h00, "bchk_q");
        step(L_D3, "d3_on_queen");
        step(PW, "done_after_queen");

        // Reset asserted while in P2
        #4;
        resetb = 1'b0;
        step(8'h00, "pre_reset_hold");
        resetb = 1'b1;
        step(L_P1, "pre_p1");
        step(L_D1, "pre_d1");
        step(L_P2, "pre_p2");
        start_hand();
        pscore = 4'd8; dscore = 4'd0;
        step(PW, "after_reset_natural");

        // Exhaustive banker tableau
        for (int d = 0; d < 8; d++) begin
            for (int r = 1; r < 14; r++) begin
                start_hand();
                pscore = 4'd3; dscore = 4'(d);
                step(L_P3, "tab_p3");
                pcard3 = 4'(r);
                step(8'h00, "tab_bchk");
                v    = (r >= 10) ? 4'd0 : 4'(r);
                draw = bank_mask[d][v];
                fin  = lights(4'd3, 4'(d));
                if (draw) begin
                    step(L_D3, $sformatf("tab_d%0d_r%0d_draw", d, r));
                    step(fin, "tab_done_after_d3");
                end else begin
                    step(fin, $sformatf("tab_d%0d_r%0d_stand", d, r));
                end
            end
        end

        // Random hands for strobe sanity
        for (int h = 0; h < 20; h++) begin
            start_hand();
            pscore = 4'($urandom_range(0, 9));
            dscore = 4'($urandom_range(0, 9));
            for (int c = 0; c < 5; c++) begin
                idle_step();
                pcard3 = 4'($urandom_range(0, 13));
                pscore = 4'($urandom_range(0, 9));
                dscore = 4'($urandom_range(0, 9));
            end
        end

        idle_step();
        #10;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
